reorder_buffer_mc: RTL and testbench

//  Parametrised multi-commit reorder buffer. Sits between the decode/issue stage and the regfile.
//  - Accepts one instruction per cycle in program order.
//  - Takes results from NUM_WB writeback ports.
//  - Retires up to COMMIT_W ready head entries per cycle.
//  - Recovers precisely: on commit of a mispredicted entry, it flushes all younger entries and redirects fetch.

---
 rtl/reorder_buffer_mc_pkg.sv | 27 ++
 rtl/reorder_buffer_mc_commit_select.sv | 40 ++++
 rtl/reorder_buffer_mc.sv | 152 +++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_mc_pkg.sv
// reorder_buffer_mc_pkg: shared entry/writeback types and sizing for the reorder buffer.
package reorder_buffer_mc_pkg;
    localparam int ROB_DEPTH      = 16;
    localparam int ROB_TAG_W      = $clog2(ROB_DEPTH);
    localparam int ROB_XLEN       = 32;
    localparam int ROB_COMMIT_MAX = 4;
    localparam int ROB_NC_W       = $clog2(ROB_COMMIT_MAX + 1);

    typedef struct packed {
        logic                valid;
        logic                rdy;
        logic                mispred;
        logic                has_rd;
        logic [4:0]          rd;
        logic [ROB_XLEN-1:0] pc;
        logic [ROB_XLEN-1:0] data;
        logic [ROB_XLEN-1:0] target;
    } rob_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [ROB_XLEN-1:0]  data;
        logic                 mispred;
        logic [ROB_XLEN-1:0]  target;
    } rob_wb_t;
endpackage

// File: rtl/reorder_buffer_mc_commit_select.sv
// reorder_buffer_mc_commit_select: scans the head window and picks the contiguous ready run,
// stopping after the first mispredicted entry (which itself retires).
module reorder_buffer_mc_commit_select
    import reorder_buffer_mc_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int TAG_W    = 4
) (
    input  logic [COMMIT_W-1:0] valid_i,
    input  logic [COMMIT_W-1:0] rdy_i,
    input  logic [COMMIT_W-1:0] mispred_i,
    input  logic [TAG_W:0]      count_i,
    output logic [COMMIT_W-1:0] mask_o,
    output logic [ROB_NC_W-1:0] ncommit_o,
    output logic                mispred_o,
    output logic [1:0]          mispred_slot_o
);
    logic run;

    always_comb begin
        mask_o         = '0;
        ncommit_o      = '0;
        mispred_o      = 1'b0;
        mispred_slot_o = '0;
        run            = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (run && valid_i[i] && rdy_i[i] && ((TAG_W+1)'(i) < count_i)) begin
                mask_o[i] = 1'b1;
                ncommit_o = ncommit_o + ROB_NC_W'(1);
                if (mispred_i[i]) begin
                    mispred_o      = 1'b1;
                    mispred_slot_o = 2'(i);
                    run            = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc: multi-commit reorder buffer with writeback bypass on operand lookup
// and precise recovery on a retiring mispredict or an external flush.
module reorder_buffer_mc
    import reorder_buffer_mc_pkg::*;
#(
    parameter  int DEPTH    = ROB_DEPTH,
    parameter  int NUM_WB   = 4,
    parameter  int COMMIT_W = 2,
    parameter  int NUM_SRC  = 2,
    parameter  int XLEN     = ROB_XLEN,
    localparam int TAG_W    = $clog2(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             disp_valid_i,
    output logic                             disp_ready_o,
    input  logic [XLEN-1:0]                  disp_pc_i,
    input  logic [4:0]                       disp_rd_i,
    input  logic                             disp_has_rd_i,
    output logic [TAG_W-1:0]                 disp_tag_o,
    input  logic [NUM_WB-1:0]                wb_valid_i,
    input  logic [NUM_WB-1:0][TAG_W-1:0]     wb_tag_i,
    input  logic [NUM_WB-1:0][XLEN-1:0]      wb_data_i,
    input  logic [NUM_WB-1:0]                wb_mispred_i,
    input  logic [NUM_WB-1:0][XLEN-1:0]      wb_target_i,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]    src_tag_i,
    output logic [NUM_SRC-1:0]               src_rdy_o,
    output logic [NUM_SRC-1:0][XLEN-1:0]     src_data_o,
    output logic [COMMIT_W-1:0]              commit_valid_o,
    output logic [COMMIT_W-1:0]              commit_has_rd_o,
    output logic [COMMIT_W-1:0][4:0]         commit_rd_o,
    output logic [COMMIT_W-1:0][XLEN-1:0]    commit_data_o,
    output logic [COMMIT_W-1:0][TAG_W-1:0]   commit_tag_o,
    input  logic                             ext_flush_i,
    output logic                             flush_valid_o,
    output logic [XLEN-1:0]                  flush_pc_o,
    output logic [TAG_W:0]                   count_o,
    output logic                             full_o,
    output logic                             empty_o
);
    rob_entry_t                      ent_q [DEPTH];
    rob_entry_t                      ent_d [DEPTH];
    rob_wb_t                         wb [NUM_WB];
    logic [TAG_W:0]                  head_q, head_d, tail_q, tail_d;
    logic [COMMIT_W-1:0][TAG_W-1:0]  hidx;
    logic [COMMIT_W-1:0]             hv, hr, hm, sel_mask;
    logic [ROB_NC_W-1:0]             ncommit;
    logic                            sel_mis, accept, flush;
    logic [1:0]                      sel_slot;

    assign count_o      = tail_q - head_q;
    assign empty_o      = head_q == tail_q;
    assign full_o       = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign disp_ready_o = ~full_o & ~flush_valid_o & ~ext_flush_i;
    assign accept       = disp_valid_i & disp_ready_o;
    assign disp_tag_o   = tail_q[TAG_W-1:0];
    assign flush        = ext_flush_i | flush_valid_o;

    always_comb begin
        for (int i = 0; i < NUM_WB; i++) begin
            wb[i] = '{valid: wb_valid_i[i], tag: wb_tag_i[i], data: wb_data_i[i],
                      mispred: wb_mispred_i[i], target: wb_target_i[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            hidx[i]            = head_q[TAG_W-1:0] + TAG_W'(i);
            hv[i]              = ent_q[hidx[i]].valid;
            hr[i]              = ent_q[hidx[i]].rdy;
            hm[i]              = ent_q[hidx[i]].mispred;
            commit_has_rd_o[i] = ent_q[hidx[i]].has_rd;
            commit_rd_o[i]     = ent_q[hidx[i]].rd;
            commit_data_o[i]   = ent_q[hidx[i]].data;
            commit_tag_o[i]    = hidx[i];
        end
    end

    reorder_buffer_mc_commit_select #(.COMMIT_W(COMMIT_W), .TAG_W(TAG_W)) u_sel (
        .valid_i        (hv),
        .rdy_i          (hr),
        .mispred_i      (hm),
        .count_i        (count_o),
        .mask_o         (sel_mask),
        .ncommit_o      (ncommit),
        .mispred_o      (sel_mis),
        .mispred_slot_o (sel_slot)
    );

    assign commit_valid_o = ext_flush_i ? '0 : sel_mask;
    assign flush_valid_o  = sel_mis & ~ext_flush_i;
    assign flush_pc_o     = flush_valid_o ? ent_q[hidx[sel_slot]].target : '0;

    // Writeback is gated on the entry being live both before and after this cycle's retire.
    always_comb begin
        ent_d  = ent_q;
        head_d = head_q + (TAG_W+1)'(ncommit);
        tail_d = tail_q + (TAG_W+1)'(accept);
        for (int i = 0; i < COMMIT_W; i++) begin
            if (commit_valid_o[i]) ent_d[hidx[i]] = '0;
        end
        if (accept) begin
            ent_d[disp_tag_o] = '{valid: 1'b1, rdy: 1'b0, mispred: 1'b0, has_rd: disp_has_rd_i,
                                  rd: disp_rd_i, pc: disp_pc_i, data: '0, target: '0};
        end
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb[w].valid && ent_q[wb[w].tag].valid && ent_d[wb[w].tag].valid) begin
                ent_d[wb[w].tag].rdy     = 1'b1;
                ent_d[wb[w].tag].data    = wb[w].data;
                ent_d[wb[w].tag].mispred = wb[w].mispred;
                ent_d[wb[w].tag].target  = wb[w].target;
            end
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ent_q  <= ent_d;
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_rdy_o[s]  = ent_q[src_tag_i[s]].valid & ent_q[src_tag_i[s]].rdy;
            src_data_o[s] = src_rdy_o[s] ? ent_q[src_tag_i[s]].data : '0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb[w].valid && wb[w].tag == src_tag_i[s] && ent_q[src_tag_i[s]].valid) begin
                    src_rdy_o[s]  = 1'b1;
                    src_data_o[s] = wb[w].data;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_WB; i++) begin : g_wa
        for (genvar j = i + 1; j < NUM_WB; j++) begin : g_wb
            assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(wb_valid_i[i] && wb_valid_i[j] && wb_tag_i[i] == wb_tag_i[j]));
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb_reorder_buffer_mc: directed scenarios with an in-order commit scoreboard.
module tb_reorder_buffer_mc;
    logic             clk = 1'b0;
    logic             rst_ni;
    logic             disp_valid, disp_ready, disp_has_rd;
    logic [31:0]      disp_pc;
    logic [4:0]       disp_rd;
    logic [3:0]       disp_tag;
    logic [3:0]       wb_valid, wb_mispred;
    logic [3:0][3:0]  wb_tag;
    logic [3:0][31:0] wb_data, wb_target;
    logic [1:0][3:0]  src_tag;
    logic [1:0]       src_rdy;
    logic [1:0][31:0] src_data;
    logic [1:0]       commit_valid, commit_has_rd;
    logic [1:0][4:0]  commit_rd;
    logic [1:0][31:0] commit_data;
    logic [1:0][3:0]  commit_tag;
    logic             ext_flush, flush_valid, full, empty;
    logic [31:0]      flush_pc;
    logic [4:0]       count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [3:0]  q[$];
    logic [3:0]  mtail;
    logic [31:0] tb_data [16];

    always #5 clk = ~clk;

    reorder_buffer_mc dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_pc_i(disp_pc),
        .disp_rd_i(disp_rd), .disp_has_rd_i(disp_has_rd), .disp_tag_o(disp_tag),
        .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
        .wb_mispred_i(wb_mispred), .wb_target_i(wb_target),
        .src_tag_i(src_tag), .src_rdy_o(src_rdy), .src_data_o(src_data),
        .commit_valid_o(commit_valid), .commit_has_rd_o(commit_has_rd), .commit_rd_o(commit_rd),
        .commit_data_o(commit_data), .commit_tag_o(commit_tag),
        .ext_flush_i(ext_flush), .flush_valid_o(flush_valid), .flush_pc_o(flush_pc),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_commits();
        logic [3:0] t;
        if (commit_valid == 2'b10) chk("commit_contig", {31'd0, commit_valid[0]}, 32'd1);
        for (int s = 0; s < 2; s++) begin
            if (commit_valid[s]) begin
                if (q.size() == 0) chk("commit_extra", {31'd0, commit_valid[s]}, 32'd0);
                else begin
                    t = q.pop_front();
                    chk("commit_tag", {28'd0, commit_tag[s]}, {28'd0, t});
                    chk("commit_data", commit_data[s], tb_data[t]);
                    chk("commit_rd", {27'd0, commit_rd[s]}, {27'd0, 5'(t + 4'd1)});
                    chk("commit_has_rd", {31'd0, commit_has_rd[s]}, 32'd1);
                end
            end
        end
        if (flush_valid) q.delete();
    endtask

    task automatic tick();
        #1;
        check_commits();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dispatch(input int n);
        for (int k = 0; k < n; k++) begin
            disp_valid  = 1'b1;
            disp_pc     = 32'h1000 + 32'(mtail) * 4;
            disp_rd     = 5'(mtail + 4'd1);
            disp_has_rd = 1'b1;
            #1;
            chk("disp_ready", {31'd0, disp_ready}, 32'd1);
            chk("disp_tag", {28'd0, disp_tag}, {28'd0, mtail});
            q.push_back(mtail);
            mtail = mtail + 4'd1;
            tick();
        end
        disp_valid = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [3:0] t, input logic [31:0] d,
                          input logic mis = 1'b0, input logic [31:0] tgt = 32'd0);
        wb_valid[p] = 1'b1; wb_tag[p] = t; wb_data[p] = d;
        wb_mispred[p] = mis; wb_target[p] = tgt;
        tb_data[t] = d;
    endtask

    task automatic clr_wb();
        wb_valid = '0; wb_mispred = '0; wb_tag = '0; wb_data = '0; wb_target = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        q.delete();
        mtail = '0;
    endtask

    initial begin
        rst_ni = 1'b0; disp_valid = 1'b0; disp_pc = '0; disp_rd = '0; disp_has_rd = 1'b0;
        src_tag = '0; ext_flush = 1'b0; mtail = '0;
        clr_wb();
        for (int i = 0; i < 16; i++) tb_data[i] = '0;
        @(negedge clk);
        #1;
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("rst_commit_valid", {30'd0, commit_valid}, 32'd0);
        chk("rst_flush_valid", {31'd0, flush_valid}, 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        chk("rst_src_rdy", {30'd0, src_rdy}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // 1: asynchronous reset mid-run
        dispatch(5);
        #1;
        chk("t1_count5", {27'd0, count}, 32'd5);
        rst_ni = 1'b0;
        #1;
        chk("t1_count", {27'd0, count}, 32'd0);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_disp_ready", {31'd0, disp_ready}, 32'd1);
        rst_ni = 1'b1;
        q.delete(); mtail = '0;
        @(negedge clk);
        dispatch(1);

        // 2: fill, then two retire and dispatch reopens a cycle later
        do_reset();
        @(negedge clk);
        dispatch(16);
        #1;
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_disp_ready", {31'd0, disp_ready}, 32'd0);
        chk("t2_count", {27'd0, count}, 32'd16);
        set_wb(0, 4'd0, 32'hA000); set_wb(1, 4'd1, 32'hA001);
        #1;
        chk("t2_no_bypass_commit", {30'd0, commit_valid}, 32'd0);
        tick();
        clr_wb();
        #1;
        chk("t2_commit_valid", {30'd0, commit_valid}, 32'd3);
        chk("t2_ready_still0", {31'd0, disp_ready}, 32'd0);
        tick();
        #1;
        chk("t2_ready_after", {31'd0, disp_ready}, 32'd1);
        chk("t2_count14", {27'd0, count}, 32'd14);

        // 3: pointer wrap with ordered retirement
        do_reset();
        @(negedge clk);
        dispatch(15);
        set_wb(0, 4'd0, 32'hB000); set_wb(1, 4'd1, 32'hB001);
        tick();
        clr_wb();
        set_wb(0, 4'd2, 32'hB002); set_wb(1, 4'd3, 32'hB003);
        #1;
        chk("t3_commit01", {30'd0, commit_valid}, 32'd3);
        tick();
        clr_wb();
        dispatch(2);
        set_wb(0, 4'd4, 32'hB004); set_wb(1, 4'd5, 32'hB005);
        set_wb(2, 4'd6, 32'hB006); set_wb(3, 4'd7, 32'hB007);
        tick();
        clr_wb();
        #1;
        chk("t3_head4", {28'd0, commit_tag[0]}, 32'd4);
        tick();
        #1;
        chk("t3_head6", {28'd0, commit_tag[0]}, 32'd6);
        chk("t3_commit67", {30'd0, commit_valid}, 32'd3);
        tick();
        #1;
        chk("t3_count", {27'd0, count}, 32'd9);

        // 4: mispredict recovery
        do_reset();
        @(negedge clk);
        dispatch(6);
        set_wb(0, 4'd2, 32'hC002); set_wb(1, 4'd3, 32'hC003);
        tick();
        clr_wb();
        set_wb(0, 4'd0, 32'hC000); set_wb(1, 4'd1, 32'hC001, 1'b1, 32'h80);
        tick();
        clr_wb();
        #1;
        chk("t4_commit_valid", {30'd0, commit_valid}, 32'd3);
        chk("t4_flush_valid", {31'd0, flush_valid}, 32'd1);
        chk("t4_flush_pc", flush_pc, 32'h80);
        chk("t4_disp_ready", {31'd0, disp_ready}, 32'd0);
        tick();
        #1;
        chk("t4_count", {27'd0, count}, 32'd0);
        chk("t4_empty", {31'd0, empty}, 32'd1);
        chk("t4_no_commit", {30'd0, commit_valid}, 32'd0);
        chk("t4_flush_drop", {31'd0, flush_valid}, 32'd0);
        tick();
        mtail = '0;

        // 5: lookup with same-cycle writeback bypass
        do_reset();
        @(negedge clk);
        dispatch(4);
        src_tag[0] = 4'd3; src_tag[1] = 4'd9;
        #1;
        chk("t5_pre_rdy", {31'd0, src_rdy[0]}, 32'd0);
        set_wb(2, 4'd3, 32'hDEAD); set_wb(3, 4'd9, 32'hBEEF);
        #1;
        chk("t5_byp_rdy", {31'd0, src_rdy[0]}, 32'd1);
        chk("t5_byp_data", src_data[0], 32'hDEAD);
        chk("t5_inv_rdy", {31'd0, src_rdy[1]}, 32'd0);
        chk("t5_inv_data", src_data[1], 32'd0);
        tick();
        clr_wb();
        #1;
        chk("t5_reg_rdy", {31'd0, src_rdy[0]}, 32'd1);
        chk("t5_reg_data", src_data[0], 32'hDEAD);
        chk("t5_inv_ignored", {31'd0, src_rdy[1]}, 32'd0);
        src_tag[1] = 4'd0;
        #1;
        chk("t5_notrdy", {31'd0, src_rdy[1]}, 32'd0);

        // 6: external flush overrides a ready head and blocks dispatch
        set_wb(0, 4'd0, 32'hE000);
        tick();
        clr_wb();
        ext_flush = 1'b1; disp_valid = 1'b1;
        #1;
        chk("t6_commit_valid", {30'd0, commit_valid}, 32'd0);
        chk("t6_flush_valid", {31'd0, flush_valid}, 32'd0);
        chk("t6_disp_ready", {31'd0, disp_ready}, 32'd0);
        tick();
        ext_flush = 1'b0; disp_valid = 1'b0;
        q.delete(); mtail = '0;
        #1;
        chk("t6_empty", {31'd0, empty}, 32'd1);
        chk("t6_count", {27'd0, count}, 32'd0);
        dispatch(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
